// File: rtl/sr_latch_driver.sv
// Clocked front end for an SR latch: synchronises and debounces set/clear requests,
// drives a fixed-width s or r pulse, then confirms the flip via the q/qbar feedback.

module sr_latch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic accept
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  // Saturating run-length counter; one acceptance per high run.
  always_comb begin
    accept = armed_q && (cnt_q == CNT_W'(DEBOUNCE_CYCLES));
    if (level) begin
      cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      armed_d = armed_q && !accept;
    end else begin
      cnt_d   = {CNT_W{1'b0}};
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= {CNT_W{1'b0}};
      armed_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

module sr_latch_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 8,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  input  logic qbar_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic done,
  output logic conflict,
  output logic err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_CHECK = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  typedef enum logic {
    OP_SET = 1'b0,
    OP_CLR = 1'b1
  } op_t;

  logic [3:0]       sync1_q, sync2_q;
  logic             set_sync_s, clr_sync_s, q_sync_s, qbar_sync_s;
  logic             acc_set_s, acc_clr_s, match_s;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             s_q, s_d, r_q, r_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             conflict_q, conflict_d, err_q, err_d;

  // Two-flop synchronisers for every asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= {set_req, clr_req, q_fb, qbar_fb};
      sync2_q <= sync1_q;
    end
  end

  assign set_sync_s  = sync2_q[3];
  assign clr_sync_s  = sync2_q[2];
  assign q_sync_s    = sync2_q[1];
  assign qbar_sync_s = sync2_q[0];

  sr_latch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_set (
    .clk   (clk),
    .rst   (rst),
    .level (set_sync_s),
    .accept(acc_set_s)
  );

  sr_latch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_clr (
    .clk   (clk),
    .rst   (rst),
    .level (clr_sync_s),
    .accept(acc_clr_s)
  );

  assign match_s = (op_q == OP_SET) ? (q_sync_s && !qbar_sync_s)
                                    : (!q_sync_s && qbar_sync_s);

  // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pulse_cnt_d = pulse_cnt_q;
    to_cnt_d    = to_cnt_q;
    done_d      = 1'b0;
    conflict_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (acc_set_s || acc_clr_s) begin
          state_d     = ST_PULSE;
          op_d        = acc_clr_s ? OP_CLR : OP_SET;
          conflict_d  = acc_set_s && acc_clr_s;
          pulse_cnt_d = CNT_W'(1);
          to_cnt_d    = {CNT_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_q >= CNT_W'(PULSE_CYCLES)) begin
          state_d  = ST_CHECK;
          to_cnt_d = CNT_W'(1);
        end else begin
          pulse_cnt_d = (pulse_cnt_q == {CNT_W{1'b1}}) ? pulse_cnt_q : pulse_cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (match_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (to_cnt_q >= CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = ST_ERROR;
        end else begin
          to_cnt_d = (to_cnt_q == {CNT_W{1'b1}}) ? to_cnt_q : to_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    s_d    = (state_d == ST_PULSE) && (op_d == OP_SET);
    r_d    = (state_d == ST_PULSE) && (op_d == OP_CLR);
    busy_d = (state_d == ST_PULSE) || (state_d == ST_CHECK);
    err_d  = (state_d == ST_ERROR);
  end

  // FSM state, counters and registered outputs; reset clears s/r immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SET;
      pulse_cnt_q <= {CNT_W{1'b0}};
      to_cnt_q    <= {CNT_W{1'b0}};
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      conflict_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pulse_cnt_q <= pulse_cnt_d;
      to_cnt_q    <= to_cnt_d;
      s_q         <= s_d;
      r_q         <= r_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      conflict_q  <= conflict_d;
      err_q       <= err_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign conflict = conflict_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: directed vector table, corner-case sequences,
// and randomized stimulus checked every cycle against an elapsed-time reference model.

module tb_sr_latch_driver;

  localparam int DEB = 4;
  localparam int PUL = 2;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic set_req = 1'b0, clr_req = 1'b0, q_fb = 1'b0, qbar_fb = 1'b1;
  logic s, r, busy, done, conflict, err;

  sr_latch_driver #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PUL),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .set_req (set_req),
    .clr_req (clr_req),
    .q_fb    (q_fb),
    .qbar_fb (qbar_fb),
    .s       (s),
    .r       (r),
    .busy    (busy),
    .done    (done),
    .conflict(conflict),
    .err     (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: raw-input history, high-run lengths, and an operation elapsed-time counter
  bit [2:0] hs, hc, hq, hqb;
  int       run_s, run_c;
  bit       acc_s, acc_c;
  bit       m_active, m_kind, m_err;
  int       m_t;
  bit       e_s, e_r, e_busy, e_done, e_conf, e_err;

  // environment: latch model and observation counters
  int fb_mode;
  bit lat_q, lat_ps, lat_pr, prev_sr;
  int n_s, n_r, n_busy, n_done, n_conf;

  typedef struct {
    bit set; bit clr;
    bit s; bit r; bit busy; bit done;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hs = 3'b0; hc = 3'b0; hq = 3'b0; hqb = 3'b0;
    run_s = 0; run_c = 0; acc_s = 1'b0; acc_c = 1'b0;
    m_active = 1'b0; m_kind = 1'b0; m_err = 1'b0; m_t = 0;
    e_s = 1'b0; e_r = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_conf = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step();
    bit match;
    if (rst) begin
      model_reset();
      return;
    end
    e_done = 1'b0;
    e_conf = 1'b0;
    match = m_kind ? (!hq[1] && hqb[1]) : (hq[1] && !hqb[1]);
    if (!m_active) begin
      if (acc_s || acc_c) begin
        m_active = 1'b1;
        m_kind   = acc_c;
        m_t      = 1;
        m_err    = 1'b0;
        e_conf   = acc_s && acc_c;
      end
    end else if (m_t > PUL) begin
      if (match) begin
        m_active = 1'b0;
        e_done   = 1'b1;
      end else if (m_t - PUL >= TMO) begin
        m_active = 1'b0;
        m_err    = 1'b1;
      end else begin
        m_t++;
      end
    end else begin
      m_t++;
    end
    e_s    = m_active && (m_t <= PUL) && !m_kind;
    e_r    = m_active && (m_t <= PUL) && m_kind;
    e_busy = m_active;
    e_err  = m_err;
    hs  = {hs[1:0], set_req};
    hc  = {hc[1:0], clr_req};
    hq  = {hq[1:0], q_fb};
    hqb = {hqb[1:0], qbar_fb};
    run_s = hs[2] ? run_s + 1 : 0;
    run_c = hc[2] ? run_c + 1 : 0;
    acc_s = (run_s == DEB);
    acc_c = (run_c == DEB);
  endtask

  task automatic compare_all();
    chk("s", s, e_s);
    chk("r", r, e_r);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("conflict", conflict, e_conf);
    chk("err", err, e_err);
    chk("s_and_r", s & r, 1'b0);
    chk("done_and_err", done & err, 1'b0);
    if ((s || r) && !prev_sr) chk("err_at_pulse_start", err, 1'b0);
    prev_sr = s || r;
  endtask

  task automatic clear_obs();
    n_s = 0; n_r = 0; n_busy = 0; n_done = 0; n_conf = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    n_s    += int'(s);
    n_r    += int'(r);
    n_busy += int'(busy);
    n_done += int'(done);
    n_conf += int'(conflict);
    case (fb_mode)
      0: begin
        if (lat_ps) lat_q = 1'b1;
        else if (lat_pr) lat_q = 1'b0;
        q_fb    = lat_q;
        qbar_fb = !lat_q;
      end
      2: begin
        q_fb    = 1'($urandom_range(0, 1));
        qbar_fb = 1'($urandom_range(0, 1));
      end
      default: ;
    endcase
    lat_ps = s;
    lat_pr = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int set_cnt, clr_cnt;
    fb_mode = 0; lat_q = 1'b0; lat_ps = 1'b0; lat_pr = 1'b0; prev_sr = 1'b0;
    clear_obs();
    model_reset();
    for (int i = 0; i < 14; i++) begin
      tbl[i].set  = (i <= 9);
      tbl[i].clr  = 1'b0;
      tbl[i].s    = (i == 6) || (i == 7);
      tbl[i].r    = 1'b0;
      tbl[i].busy = (i >= 6) && (i <= 9);
      tbl[i].done = (i == 10);
    end

    #1;
    do_reset();
    repeat (5) tick();

    // set path: entry i is sampled on edge i counted from the first high sample
    for (int i = 0; i < 14; i++) begin
      set_req = tbl[i].set;
      clr_req = tbl[i].clr;
      tick();
      chk("tbl_s", s, tbl[i].s);
      chk("tbl_r", r, tbl[i].r);
      chk("tbl_busy", busy, tbl[i].busy);
      chk("tbl_done", done, tbl[i].done);
    end
    chk("set_latch_q", q_fb, 1'b1);

    // clear path from a set latch
    clear_obs();
    clr_req = 1'b1;
    repeat (10) tick();
    clr_req = 1'b0;
    repeat (12) tick();
    chk("clr_r_cycles", n_r, 2);
    chk("clr_s_cycles", n_s, 0);
    chk("clr_done", n_done, 1);
    chk("clr_latch_q", q_fb, 1'b0);
    chk("clr_latch_qbar", qbar_fb, 1'b1);

    // simultaneous requests: clear wins
    clear_obs();
    set_req = 1'b1; clr_req = 1'b1;
    repeat (10) tick();
    set_req = 1'b0; clr_req = 1'b0;
    repeat (12) tick();
    chk("sim_conflict", n_conf, 1);
    chk("sim_r_cycles", n_r, 2);
    chk("sim_s_cycles", n_s, 0);
    chk("sim_done", n_done, 1);

    // bounce rejection: three-cycle highs never reach the debounce threshold
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      set_req = ((i % 4) != 3);
      tick();
    end
    set_req = 1'b0;
    repeat (4) tick();
    chk("bounce_s", n_s, 0);
    chk("bounce_r", n_r, 0);
    chk("bounce_busy", n_busy, 0);
    chk("bounce_done", n_done, 0);

    // timeout with stuck feedback, then recovery through a clear
    clear_obs();
    fb_mode = 1; q_fb = 1'b0; qbar_fb = 1'b1;
    set_req = 1'b1;
    repeat (10) tick();
    set_req = 1'b0;
    repeat (14) tick();
    chk("to_s_cycles", n_s, 2);
    chk("to_done", n_done, 0);
    chk("to_err", err, 1'b1);
    fb_mode = 0; lat_q = 1'b0;
    clear_obs();
    clr_req = 1'b1;
    repeat (10) tick();
    clr_req = 1'b0;
    repeat (12) tick();
    chk("rec_err", err, 1'b0);
    chk("rec_r_cycles", n_r, 2);
    chk("rec_done", n_done, 1);

    // reset during the second cycle of an s pulse
    set_req = 1'b1;
    repeat (8) tick();
    chk("pre_rst_s", s, 1'b1);
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_async_s", s, 1'b0);
    compare_all();
    set_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clear_obs();
    repeat (20) tick();
    chk("post_rst_s", n_s, 0);
    chk("post_rst_r", n_r, 0);
    chk("post_rst_busy", n_busy, 0);
    chk("post_rst_done", n_done, 0);

    // randomized run against the reference model
    set_cnt = 0; clr_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (set_cnt == 0) begin
        set_req = !set_req && ($urandom_range(0, 3) == 0);
        set_cnt = $urandom_range(1, 12);
      end else begin
        set_cnt--;
      end
      if (clr_cnt == 0) begin
        clr_req = !clr_req && ($urandom_range(0, 3) == 0);
        clr_cnt = $urandom_range(1, 12);
      end else begin
        clr_cnt--;
      end
      if ($urandom_range(0, 199) == 0) fb_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 699) == 0) do_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
